// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial-pattern detection controller.
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned LW_DEF    = $clog2(PAT_W_DEF + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_det_match.sv
// Pattern matcher: history shift register, fill counter and comparator.
// Build option: SEQ_DET_OVERLAP_EN selects overlapping detection (history reused after a hit).
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned LW    = LW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_bit,
  input  logic             valid,
  input  logic             clear,
  input  logic [LW-1:0]    len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_shift, mask;
  logic [LW-1:0]    fill_q, fill_d, fill_inc;

  // Compare window mask, next history and saturating fill; hit reflects the bit offered now.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LW'(i) < len);
    end
    hist_shift = (hist_q << 1) | PAT_W'(data_bit);
    fill_inc   = (fill_q >= len) ? len : fill_q + LW'(1);
    hit        = valid && (fill_inc >= len) && ((hist_shift & mask) == (pattern & mask));
`ifdef SEQ_DET_OVERLAP_EN
    fill_d = fill_inc;
`else
    // A hit consumes its bits: the next match needs len fresh ones.
    fill_d = hit ? '0 : fill_inc;
`endif
  end

  // History and fill state; clear wins over a shifted-in bit.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (valid) begin
      hist_q <= hist_shift;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for programmable serial-pattern detection: config handshake, run FSM,
// bit/match counters and registered outputs.
// Build option: SEQ_DET_OVERLAP_EN (consumed by seq_det_match) enables overlapping matches.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned LW   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic             abort,
  input  logic             signal,
  input  logic             signal_valid,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CNT_W-1:0] window_q, window_d, max_q, max_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d, bitcnt_inc;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, mcnt_next;
  logic             out_q, out_d, cfg_err_q, cfg_err_d;
  logic             cfg_fire, len_ok, take_bit, hit;

  assign cfg_fire = cfg_valid && (state_q == StIdle);
  assign len_ok   = (cfg_len != '0) && (cfg_len <= LW'(PAT_W));
  // abort beats a bit offered in the same cycle
  assign take_bit = (state_q == StRun) && signal_valid && !abort;

  seq_det_match #(
    .PAT_W (PAT_W),
    .LW    (LW)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .data_bit (signal),
    .valid    (take_bit),
    .clear    (cfg_fire),
    .len      (len_q),
    .pattern  (pattern_q),
    .hit      (hit)
  );

  // Saturating counter increments for the current bit.
  always_comb begin
    bitcnt_inc = (bitcnt_q == '1) ? bitcnt_q : bitcnt_q + CNT_W'(1);
    mcnt_next  = (hit && match_cnt_q != '1) ? match_cnt_q + CNT_W'(1) : match_cnt_q;
  end

  // FSM next state, configuration latch and counter updates.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    window_d    = window_q;
    max_d       = max_q;
    bitcnt_d    = bitcnt_q;
    match_cnt_d = match_cnt_q;
    cfg_err_d   = cfg_err_q;
    out_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          pattern_d   = cfg_pattern;
          len_d       = cfg_len;
          window_d    = cfg_window;
          max_d       = cfg_max;
          bitcnt_d    = '0;
          match_cnt_d = '0;
          cfg_err_d   = !len_ok;
          state_d     = len_ok ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
        end else if (signal_valid) begin
          bitcnt_d    = bitcnt_inc;
          match_cnt_d = mcnt_next;
          out_d       = hit;
          if ((window_q != '0 && bitcnt_inc == window_q) ||
              (max_q != '0 && mcnt_next == max_q)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      pattern_q   <= '0;
      len_q       <= '0;
      window_q    <= '0;
      max_q       <= '0;
      bitcnt_q    <= '0;
      match_cnt_q <= '0;
      out_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      window_q    <= window_d;
      max_q       <= max_d;
      bitcnt_q    <= bitcnt_d;
      match_cnt_q <= match_cnt_d;
      out_q       <= out_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = match_cnt_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign cfg_ready = (state_q == StIdle);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (default PAT_W=8, CNT_W=8).
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_window;
  logic [7:0] cfg_max;
  logic       abort;
  logic       signal;
  logic       signal_valid;
  logic       out;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Main stream and hand-derived per-bit match pulses for pattern 101, len 3.
  int bits_a[10] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1};
`ifdef SEQ_DET_OVERLAP_EN
  int exp_out_a[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
`else
  int exp_out_a[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
`endif

  seq_det_ctrl #(
    .PAT_W (8),
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_window   (cfg_window),
    .cfg_max      (cfg_max),
    .abort        (abort),
    .signal       (signal),
    .signal_valid (signal_valid),
    .out          (out),
    .match_cnt    (match_cnt),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] win, input logic [7:0] mx);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_window  = win;
    cfg_max     = mx;
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  task automatic send_bit(input int b);
    signal       = b[0];
    signal_valid = 1'b1;
    step();
    signal_valid = 1'b0;
    signal       = 1'b0;
  endtask

  // Main 10-bit run, optionally with two idle cycles after each bit.
  task automatic run_main(input string name, input int gap);
    int cnt;
    cnt = 0;
    configure(8'b101, 4'd3, 8'd10, 8'd0);
    check_eq({name, "_busy"}, 32'(busy), 1);
    check_eq({name, "_cfg_err_clr"}, 32'(cfg_err), 0);
    for (int i = 0; i < 10; i++) begin
      send_bit(bits_a[i]);
      cnt += exp_out_a[i];
      check_eq($sformatf("%s_out_b%0d", name, i + 1), 32'(out), 32'(exp_out_a[i]));
      check_eq($sformatf("%s_cnt_b%0d", name, i + 1), 32'(match_cnt), 32'(cnt));
      check_eq($sformatf("%s_done_b%0d", name, i + 1), 32'(done), 32'(i == 9));
      if (gap != 0 && i != 9) begin
        step();
        check_eq($sformatf("%s_gap_out_b%0d", name, i + 1), 32'(out), 0);
        step();
      end
    end
    step();
    check_eq({name, "_ready_after"}, 32'(cfg_ready), 1);
    check_eq({name, "_done_1cyc"}, 32'(done), 0);
    check_eq({name, "_cnt_hold"}, 32'(match_cnt), 32'(cnt));
  endtask

  initial begin
    rst          = 1'b0;
    cfg_valid    = 1'b0;
    cfg_pattern  = '0;
    cfg_len      = '0;
    cfg_window   = '0;
    cfg_max      = '0;
    abort        = 1'b0;
    signal       = 1'b0;
    signal_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    check_eq("rst_ready", 32'(cfg_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_out", 32'(out), 0);
    check_eq("rst_cnt", 32'(match_cnt), 0);
    check_eq("rst_cfg_err", 32'(cfg_err), 0);

    // Bits while idle are ignored.
    send_bit(1);
    check_eq("idle_bit_out", 32'(out), 0);

    run_main("main", 0);

    // Match limit 1: stops right after the first match.
    configure(8'b101, 4'd3, 8'd10, 8'd1);
    for (int i = 0; i < 3; i++) begin
      send_bit(bits_a[i]);
    end
    check_eq("lim_out", 32'(out), 1);
    check_eq("lim_done", 32'(done), 1);
    check_eq("lim_cnt", 32'(match_cnt), 1);
    for (int i = 3; i < 10; i++) begin
      send_bit(bits_a[i]);
      check_eq($sformatf("lim_ign_out_b%0d", i + 1), 32'(out), 0);
      check_eq($sformatf("lim_ign_cnt_b%0d", i + 1), 32'(match_cnt), 1);
    end
    check_eq("lim_ready", 32'(cfg_ready), 1);

    // Abort: pattern 10, unlimited; the bit offered with abort would have matched.
    configure(8'b10, 4'd2, 8'd0, 8'd0);
    send_bit(1);
    send_bit(0);
    check_eq("abt_out_b2", 32'(out), 1);
    send_bit(1);
    send_bit(1);
    check_eq("abt_busy", 32'(busy), 1);
    signal       = 1'b1;
    signal_valid = 1'b1;
    signal       = 1'b0;
    abort        = 1'b1;
    step();
    signal_valid = 1'b0;
    check_eq("abt_done", 32'(done), 1);
    check_eq("abt_out_discard", 32'(out), 0);
    check_eq("abt_cnt_keep", 32'(match_cnt), 1);
    check_eq("abt_busy_low", 32'(busy), 0);
    step();
    check_eq("abt_ready", 32'(cfg_ready), 1);
    step();
    check_eq("abt_idle_ignored", 32'(done), 0);
    abort = 1'b0;

    // Illegal lengths: straight to DONE, counter cleared, never busy.
    configure(8'b101, 4'd0, 8'd10, 8'd0);
    check_eq("ill0_done", 32'(done), 1);
    check_eq("ill0_err", 32'(cfg_err), 1);
    check_eq("ill0_busy", 32'(busy), 0);
    check_eq("ill0_cnt", 32'(match_cnt), 0);
    step();
    check_eq("ill0_ready", 32'(cfg_ready), 1);
    check_eq("ill0_busy2", 32'(busy), 0);
    check_eq("ill0_err_hold", 32'(cfg_err), 1);
    configure(8'b101, 4'd9, 8'd10, 8'd0);
    check_eq("ill9_done", 32'(done), 1);
    check_eq("ill9_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("rst_err_clr", 32'(cfg_err), 0);

    // Reset mid-run on the cycle a matching bit arrives.
    configure(8'b101, 4'd3, 8'd0, 8'd0);
    send_bit(1);
    send_bit(0);
    signal       = 1'b1;
    signal_valid = 1'b1;
    rst          = 1'b0;
    step();
    signal_valid = 1'b0;
    signal       = 1'b0;
    check_eq("mrst_out", 32'(out), 0);
    check_eq("mrst_cnt", 32'(match_cnt), 0);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_done", 32'(done), 0);
    check_eq("mrst_ready", 32'(cfg_ready), 1);
    rst = 1'b1;
    step();
    check_eq("mrst_idle", 32'(busy), 0);
    configure(8'b101, 4'd3, 8'd0, 8'd0);
    send_bit(1);
    send_bit(0);
    check_eq("mrst_b2_out", 32'(out), 0);
    send_bit(1);
    check_eq("mrst_b3_out", 32'(out), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("mrst_abort_done", 32'(done), 1);
    step();

    run_main("gap", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
